// File: rtl/uart_prog_loader.sv
// UART program loader: parses SYNC/LEN/DATA/CSUM frames from a byte stream
// and writes little-endian 32-bit words into instruction memory while holding
// the CPU in reset.
module uart_prog_loader #(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned TIMEOUT_CYC = 100000
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [7:0]        rx_data_i,
   input  logic              rx_valid_i,
   output logic              imem_we_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   output logic [31:0]       imem_wdata_o,
   output logic              cpu_hold_o,
   output logic              load_done_o,
   output logic              load_err_o
);

   localparam logic [7:0]  SyncByte = 8'hA5;
   localparam int unsigned TmoW     = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {StIdle, StLen, StData, StCsum, StDone, StErr} state_e;

   state_e            state_q, state_d;
   logic [7:0]        len_q, len_d;
   logic [7:0]        word_cnt_q, word_cnt_d;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [7:0]        csum_q, csum_d;
   logic [23:0]       shift_q, shift_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [TmoW-1:0]   tmo_q, tmo_d;
   logic              hold_q, hold_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   // Frame parser, word assembly and inter-byte timeout
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      word_cnt_d = word_cnt_q;
      byte_idx_d = byte_idx_q;
      csum_d     = csum_q;
      shift_d    = shift_q;
      addr_d     = addr_q;
      we_d       = 1'b0;
      wdata_d    = wdata_q;
      tmo_d      = tmo_q;
      hold_d     = hold_q;
      done_d     = done_q;
      err_d      = err_q;

      // Address advances the cycle after each write strobe
      if (we_q) begin
         addr_d = addr_q + 1'b1;
      end

      unique case (state_q)
         StIdle, StDone, StErr: begin
            if (rx_valid_i && rx_data_i == SyncByte) begin
               state_d    = StLen;
               hold_d     = 1'b1;
               done_d     = 1'b0;
               err_d      = 1'b0;
               addr_d     = '0;
               word_cnt_d = '0;
               byte_idx_d = '0;
               csum_d     = '0;
               tmo_d      = '0;
            end
         end
         StLen, StData, StCsum: begin
            if (rx_valid_i) begin
               tmo_d = '0;
               if (state_q == StLen) begin
                  len_d   = rx_data_i;
                  state_d = (rx_data_i != 8'd0) ? StData : StCsum;
               end else if (state_q == StData) begin
                  csum_d     = csum_q + rx_data_i;
                  byte_idx_d = byte_idx_q + 2'd1;
                  unique case (byte_idx_q)
                     2'd0: shift_d[7:0]   = rx_data_i;
                     2'd1: shift_d[15:8]  = rx_data_i;
                     2'd2: shift_d[23:16] = rx_data_i;
                     default: begin
                        we_d       = 1'b1;
                        wdata_d    = {rx_data_i, shift_q};
                        word_cnt_d = word_cnt_q + 8'd1;
                        if (8'(word_cnt_q + 8'd1) == len_q) begin
                           state_d = StCsum;
                        end
                     end
                  endcase
               end else begin
                  if (rx_data_i == csum_q) begin
                     state_d = StDone;
                     hold_d  = 1'b0;
                     done_d  = 1'b1;
                  end else begin
                     state_d = StErr;
                     err_d   = 1'b1;
                  end
               end
            end else if (tmo_q == TmoW'(TIMEOUT_CYC - 1)) begin
               state_d = StErr;
               err_d   = 1'b1;
               tmo_d   = '0;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         len_q      <= '0;
         word_cnt_q <= '0;
         byte_idx_q <= '0;
         csum_q     <= '0;
         shift_q    <= '0;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         tmo_q      <= '0;
         hold_q     <= 1'b1;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         word_cnt_q <= word_cnt_d;
         byte_idx_q <= byte_idx_d;
         csum_q     <= csum_d;
         shift_q    <= shift_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         wdata_q    <= wdata_d;
         tmo_q      <= tmo_d;
         hold_q     <= hold_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign imem_we_o    = we_q;
   assign imem_addr_o  = addr_q;
   assign imem_wdata_o = wdata_q;
   assign cpu_hold_o   = hold_q;
   assign load_done_o  = done_q;
   assign load_err_o   = err_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader: expected writes are queued by the
// stimulus, a negedge monitor pops and compares every imem write.
module tb_uart_prog_loader;

   localparam int unsigned AW  = 2;
   localparam int unsigned TMO = 20;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [7:0]    rx_data = 8'h00;
   logic          rx_valid = 1'b0;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          cpu_hold;
   logic          load_done;
   logic          load_err;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   wr_t exp_q[$];

   uart_prog_loader #(
      .ADDR_W     (AW),
      .TIMEOUT_CYC(TMO)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .rx_data_i   (rx_data),
      .rx_valid_i  (rx_valid),
      .imem_we_o   (imem_we),
      .imem_addr_o (imem_addr),
      .imem_wdata_o(imem_wdata),
      .cpu_hold_o  (cpu_hold),
      .load_done_o (load_done),
      .load_err_o  (load_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input logic [AW-1:0] a, input logic [31:0] d);
      wr_t w;
      w.addr = a;
      w.data = d;
      exp_q.push_back(w);
   endtask

   task automatic send(input logic [7:0] b);
      @(posedge clk);
      #1;
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_status(input string name, input logic d, input logic e, input logic h);
      chk({name, ".done"}, {31'd0, load_done}, {31'd0, d});
      chk({name, ".err"},  {31'd0, load_err},  {31'd0, e});
      chk({name, ".hold"}, {31'd0, cpu_hold},  {31'd0, h});
   endtask

   task automatic chk_reset(input string name);
      chk({name, ".we"},    {31'd0, imem_we}, 32'd0);
      chk({name, ".addr"},  {30'd0, imem_addr}, 32'd0);
      chk({name, ".wdata"}, imem_wdata, 32'd0);
      chk_status(name, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic drain(input string name);
      chk({name, ".pending"}, exp_q.size(), 32'd0);
      exp_q.delete();
   endtask

   // Monitor: every write strobe must match the head of the scoreboard
   always @(negedge clk) begin
      if (rst_n && imem_we) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got addr %h data %h, expected none",
                     imem_addr, imem_wdata);
         end else begin
            wr_t w;
            w = exp_q.pop_front();
            chk("wr.addr", {30'd0, imem_addr}, {30'd0, w.addr});
            chk("wr.data", imem_wdata, w.data);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      chk_reset("reset");
      rst_n = 1'b1;
      idle(2);

      // Single word, good checksum
      push(2'd0, 32'h0000_0013);
      send(8'hA5); send(8'h01); send(8'h13); send(8'h00); send(8'h00); send(8'h00);
      send(8'h13);
      chk_status("one_word", 1'b1, 1'b0, 1'b0);
      idle(2);
      drain("one_word");

      // Two words, checksum 0x24
      push(2'd0, 32'h0403_0201);
      push(2'd1, 32'h0807_0605);
      send(8'hA5); send(8'h02);
      for (int k = 1; k <= 8; k++) send(8'(k));
      send(8'h24);
      chk_status("two_words", 1'b1, 1'b0, 1'b0);
      idle(2);
      drain("two_words");

      // Bad checksum: word still written
      push(2'd0, 32'h0000_0013);
      send(8'hA5); send(8'h01); send(8'h13); send(8'h00); send(8'h00); send(8'h00);
      send(8'h14);
      chk_status("bad_csum", 1'b0, 1'b1, 1'b1);
      idle(2);
      drain("bad_csum");

      // Timeout mid-word, then empty frame
      send(8'hA5); send(8'h01); send(8'h13); send(8'h00);
      idle(TMO - 3);
      chk_status("pre_timeout", 1'b0, 1'b0, 1'b1);
      idle(5);
      chk_status("timeout", 1'b0, 1'b1, 1'b1);
      send(8'hA5); send(8'h00); send(8'h00);
      chk_status("empty_frame", 1'b1, 1'b0, 1'b0);
      idle(2);
      drain("timeout");

      // Byte arriving exactly as the timeout would expire is accepted
      push(2'd0, 32'h0000_0013);
      send(8'hA5); send(8'h01);
      idle(TMO - 2);
      send(8'h13);
      chk_status("tmo_edge", 1'b0, 1'b0, 1'b1);
      send(8'h00); send(8'h00); send(8'h00); send(8'h13);
      chk_status("tmo_edge_end", 1'b1, 1'b0, 1'b0);
      idle(2);
      drain("tmo_edge");

      // Address wraps at 2^AW; checksum of 0x10..0x23 is 0xFE
      push(2'd0, 32'h1312_1110);
      push(2'd1, 32'h1716_1514);
      push(2'd2, 32'h1B1A_1918);
      push(2'd3, 32'h1F1E_1D1C);
      push(2'd0, 32'h2322_2120);
      send(8'hA5); send(8'h05);
      for (int k = 0; k < 20; k++) send(8'(8'h10 + k));
      send(8'hFE);
      chk_status("wrap", 1'b1, 1'b0, 1'b0);
      idle(2);
      drain("wrap");

      // Non-sync bytes ignored in IDLE; 0xA5 inside data is plain data
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      send(8'hFF); send(8'h00);
      chk_status("idle_junk", 1'b0, 1'b0, 1'b1);
      push(2'd0, 32'h3322_11A5);
      send(8'hA5); send(8'h01); send(8'hA5); send(8'h11); send(8'h22); send(8'h33);
      send(8'h0B);
      chk_status("a5_data", 1'b1, 1'b0, 1'b0);
      idle(2);
      drain("a5_data");

      // Reset mid-frame abandons it; next frame loads from address 0
      send(8'hA5); send(8'h02); send(8'h01); send(8'h02);
      rst_n = 1'b0;
      #2;
      chk_reset("mid_reset");
      idle(1);
      rst_n = 1'b1;
      send(8'h03); send(8'h04);
      chk_status("post_reset_junk", 1'b0, 1'b0, 1'b1);
      push(2'd0, 32'hEFBE_ADDE);
      send(8'hA5); send(8'h01); send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
      send(8'h38);
      chk_status("reload", 1'b1, 1'b0, 1'b0);
      idle(2);
      drain("reload");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_prog_loader.md
UART_PROG_LOADER -- requirements
Module: uart_prog_loader

Interface
REQ-001 Parameter ADDR_W, default 8: instruction-memory word-address width.
REQ-002 Parameter TIMEOUT_CYC, default 100000: inter-byte timeout in clk cycles, minimum 2.
REQ-003 clk  input  1  single system clock; all logic rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 rx_data  input  8  received byte from UART receiver.
REQ-006 rx_valid  input  1  one-cycle strobe; rx_data is valid when high.
REQ-007 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-008 imem_addr  output  ADDR_W  word address of current write.
REQ-009 imem_wdata  output  32  assembled instruction word.
REQ-010 cpu_hold  output  1  high keeps the pipeline in reset while loading.
REQ-011 load_done  output  1  level; last load completed with a good checksum.
REQ-012 load_err  output  1  level; last load aborted (checksum mismatch or timeout).

Function
REQ-013 Frame format SHALL be: SYNC byte 0xA5, LEN byte N (word count 0..255), 4*N data bytes, CSUM byte.
REQ-014 Each word SHALL be assembled little-endian: first byte to [7:0], fourth byte to [31:24].
REQ-015 States SHALL be IDLE, LEN, DATA, CSUM, DONE, ERR; the state SHALL change only on a cycle with rx_valid=1, except on timeout.
REQ-016 In IDLE, DONE or ERR, rx_data=0xA5 with rx_valid SHALL go to LEN, set cpu_hold=1, clear load_done/load_err, zero the address, byte counter and checksum; any other byte SHALL be ignored.
REQ-017 LEN SHALL capture N and go to DATA if N>0, otherwise to CSUM.
REQ-018 In DATA, every byte SHALL be added to an 8-bit running checksum (sum modulo 256).
REQ-019 On the 4th byte of a word, imem_we SHALL be high for exactly the following cycle, with imem_wdata = the full word and imem_addr = the word index (1-cycle latency).
REQ-020 imem_addr SHALL increment after each write and wrap modulo 2^ADDR_W when N exceeds the memory depth.
REQ-021 After the N-th word's last byte, the state SHALL go to CSUM.
REQ-022 In CSUM, a byte equal to the running checksum SHALL go to DONE; otherwise to ERR.
REQ-023 DONE SHALL drive load_done=1 and cpu_hold=0 from the cycle after the CSUM byte.
REQ-024 ERR SHALL drive load_err=1 and keep cpu_hold=1; words already written are not rolled back.
REQ-025 In LEN, DATA and CSUM, a counter SHALL count cycles since the last rx_valid; reaching TIMEOUT_CYC SHALL enter ERR.
REQ-026 If rx_valid arrives in the cycle the timeout would expire, the byte SHALL be processed and the counter cleared.
REQ-027 A 0xA5 received in LEN, DATA or CSUM SHALL be treated as ordinary data, never as a resync.
REQ-028 imem_we SHALL never be high outside DATA-originated writes; in particular, not in CSUM, DONE, ERR or IDLE.

Reset
REQ-029 On rst_n=0, asynchronously: state=IDLE, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, load_done=0, load_err=0, all counters and checksum 0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame; after release, only a new 0xA5 starts a load.

Verification
REQ-031 Bytes A5 01 13 00 00 00 13 -> one write, addr 0, data 0x00000013, load_done=1, cpu_hold=0.
REQ-032 Bytes A5 02 + 8 bytes 01..08 + 24 -> writes 0x04030201 @0 and 0x08070605 @1, load_done=1.
REQ-033 Bytes A5 01 13 00 00 00 14 -> one write occurs, then load_err=1, cpu_hold=1, load_done=0.
REQ-034 Bytes A5 01 13 00, then idle for TIMEOUT_CYC cycles -> load_err=1, no write; a later A5 00 00 -> load_done=1, zero writes.
REQ-035 Bytes FF 00 in IDLE -> no state change, cpu_hold stays 1; a data byte 0xA5 inside a word is stored, not treated as resync.
REQ-036 rst_n pulsed low after the 2nd data byte -> all outputs at reset values; the next full frame loads from addr 0.
